gpio_irq: RTL and testbench

GPIO_IRQ -- requirements
Module: gpio_irq

---
 rtl/gpio_irq.sv | 88 ++++++++
 tb/tb_gpio_irq.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_irq.sv
// GPIO edge-detect interrupt controller: per-pin rise/fall detection into
// write-1-to-clear pending bits, gated by irq_enable into a registered irq.
module gpio_irq #(
    parameter logic [31:0] BASE_ADDR = 32'h4040
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] pin_in,
    input  logic [15:0] data_bus_write,
    output logic [15:0] data_bus_read,
    input  logic [31:0] data_bus_addr,
    input  logic [1:0]  data_bus_mode,
    input  logic        data_bus_select,
    output logic        irq
);

    localparam logic [31:0] ADDR_IE   = BASE_ADDR;
    localparam logic [31:0] ADDR_RISE = BASE_ADDR + 32'h4;
    localparam logic [31:0] ADDR_FALL = BASE_ADDR + 32'h8;
    localparam logic [31:0] ADDR_PEND = BASE_ADDR + 32'hC;
    localparam logic [31:0] ADDR_ACT  = BASE_ADDR + 32'h10;

    logic [15:0] irq_enable;
    logic [15:0] rise_en;
    logic [15:0] fall_en;
    logic [15:0] pending;
    logic [15:0] prev;
    logic        primed;

    logic        wr_en;
    logic [15:0] rise;
    logic [15:0] fall;
    logic [15:0] evt;
    logic [15:0] clr;

    assign wr_en = data_bus_select && (data_bus_mode == 2'b10);

    // Edges are suppressed until prev holds a real post-reset sample.
    always_comb begin
        rise = '0;
        fall = '0;
        if (primed) begin
            rise = pin_in & ~prev;
            fall = ~pin_in & prev;
        end
        evt = (rise & rise_en) | (fall & fall_en);
        clr = (wr_en && (data_bus_addr == ADDR_PEND)) ? data_bus_write : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_enable <= '0;
            rise_en    <= '0;
            fall_en    <= '0;
            pending    <= '0;
            prev       <= '0;
            primed     <= 1'b0;
            irq        <= 1'b0;
        end else begin
            prev    <= pin_in;
            primed  <= 1'b1;
            // OR-ing the event after the clear makes a same-cycle set win.
            pending <= (pending & ~clr) | evt;
            irq     <= |(pending & irq_enable);
            if (wr_en) begin
                case (data_bus_addr)
                    ADDR_IE:   irq_enable <= data_bus_write;
                    ADDR_RISE: rise_en    <= data_bus_write;
                    ADDR_FALL: fall_en    <= data_bus_write;
                    default:   ;
                endcase
            end
        end
    end

    always_comb begin
        data_bus_read = '0;
        case (data_bus_addr)
            ADDR_IE:   data_bus_read = irq_enable;
            ADDR_RISE: data_bus_read = rise_en;
            ADDR_FALL: data_bus_read = fall_en;
            ADDR_PEND: data_bus_read = pending;
            ADDR_ACT:  data_bus_read = pending & irq_enable;
            default:   data_bus_read = '0;
        endcase
    end

endmodule

// File: tb/tb_gpio_irq.sv
// Bench for gpio_irq: directed scenarios with literal expectations plus a
// randomized run, all compared every cycle against a register-level model.
module tb_gpio_irq;

    localparam logic [31:0] B = 32'h4040;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pin_in;
    logic [15:0] data_bus_write;
    logic [15:0] data_bus_read;
    logic [31:0] data_bus_addr;
    logic [1:0]  data_bus_mode;
    logic        data_bus_select;
    logic        irq;

    int checks = 0;
    int errors = 0;

    gpio_irq #(.BASE_ADDR(B)) dut (
        .clk            (clk),
        .reset          (reset),
        .pin_in         (pin_in),
        .data_bus_write (data_bus_write),
        .data_bus_read  (data_bus_read),
        .data_bus_addr  (data_bus_addr),
        .data_bus_mode  (data_bus_mode),
        .data_bus_select(data_bus_select),
        .irq            (irq)
    );

    always #5 clk = ~clk;

    // Register-level reference state.
    logic [15:0] m_ie, m_rise, m_fall, m_pend, m_prev;
    logic        m_primed, m_irq;

    function automatic logic wr_hit(input logic [31:0] a);
        return data_bus_select && (data_bus_mode == 2'b10) && (data_bus_addr == a);
    endfunction

    function automatic logic [15:0] cur_event();
        logic [15:0] r;
        logic [15:0] f;
        r = m_primed ? (pin_in & ~m_prev) : 16'h0;
        f = m_primed ? (~pin_in & m_prev) : 16'h0;
        return (r & m_rise) | (f & m_fall);
    endfunction

    function automatic logic [15:0] cur_clear();
        return wr_hit(B + 32'hC) ? data_bus_write : 16'h0;
    endfunction

    function automatic logic [15:0] m_read(input logic [31:0] a);
        if (a == B)          return m_ie;
        if (a == B + 32'h4)  return m_rise;
        if (a == B + 32'h8)  return m_fall;
        if (a == B + 32'hC)  return m_pend;
        if (a == B + 32'h10) return m_pend & m_ie;
        return 16'h0;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ie <= '0; m_rise <= '0; m_fall <= '0; m_pend <= '0;
            m_prev <= '0; m_primed <= 1'b0; m_irq <= 1'b0;
        end else begin
            m_pend   <= (m_pend & ~cur_clear()) | cur_event();
            m_irq    <= (m_pend & m_ie) != 16'h0;
            m_prev   <= pin_in;
            m_primed <= 1'b1;
            if (wr_hit(B))         m_ie   <= data_bus_write;
            if (wr_hit(B + 32'h4)) m_rise <= data_bus_write;
            if (wr_hit(B + 32'h8)) m_fall <= data_bus_write;
        end
    end

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_irq", {15'h0, irq}, {15'h0, m_irq});
        chk("model_read", data_bus_read, m_read(data_bus_addr));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        data_bus_select = 1'b0;
        data_bus_mode   = 2'b00;
    endtask

    task automatic wr(input logic [31:0] a, input logic [15:0] d);
        data_bus_select = 1'b1;
        data_bus_mode   = 2'b10;
        data_bus_addr   = a;
        data_bus_write  = d;
        tick();
        idle();
    endtask

    task automatic rd(input string name, input logic [31:0] a, input logic [15:0] exp);
        data_bus_addr = a;
        data_bus_mode = 2'b00;
        #1;
        chk(name, data_bus_read, exp);
    endtask

    logic [31:0] addrs [8];

    initial begin
        addrs = '{B, B + 32'h4, B + 32'h8, B + 32'hC, B + 32'hC, B + 32'h10, B + 32'h14, B - 32'h4};
        reset = 1'b1;
        pin_in = '0;
        data_bus_write = '0;
        data_bus_addr = B;
        idle();
        tick();
        tick();
        chk("reset_irq", {15'h0, irq}, 16'h0);
        rd("reset_pend", B + 32'hC, 16'h0);
        reset = 1'b0;

        // Rising edge interrupt
        wr(B, 16'h0001);
        wr(B + 32'h4, 16'h0001);
        pin_in = 16'h0001;
        tick();
        rd("rise_pend", B + 32'hC, 16'h0001);
        chk("rise_irq_lat", {15'h0, irq}, 16'h0);
        tick();
        chk("rise_irq", {15'h0, irq}, 16'h1);
        rd("rise_active", B + 32'h10, 16'h0001);

        // Clear, then clear colliding with a new rising edge
        wr(B + 32'hC, 16'h0001);
        rd("clr_pend", B + 32'hC, 16'h0);
        chk("clr_irq_lat", {15'h0, irq}, 16'h1);
        tick();
        chk("clr_irq", {15'h0, irq}, 16'h0);
        pin_in = 16'h0000;
        tick();
        pin_in = 16'h0001;
        wr(B + 32'hC, 16'h0001);
        rd("set_wins", B + 32'hC, 16'h0001);
        wr(B + 32'hC, 16'h0001);
        tick();
        rd("clr2_pend", B + 32'hC, 16'h0);

        // Falling edge, masked then enabled
        wr(B, 16'h0000);
        wr(B + 32'h8, 16'h8000);
        pin_in = 16'h8001;
        tick();
        pin_in = 16'h0001;
        tick();
        rd("fall_pend", B + 32'hC, 16'h8000);
        tick();
        chk("fall_masked", {15'h0, irq}, 16'h0);
        wr(B, 16'h8000);
        chk("fall_en_lat", {15'h0, irq}, 16'h0);
        tick();
        chk("fall_irq", {15'h0, irq}, 16'h1);
        rd("fall_active", B + 32'h10, 16'h8000);

        // Async reset mid-operation, pins held high through reset
        reset = 1'b1;
        #1;
        chk("async_irq", {15'h0, irq}, 16'h0);
        rd("async_pend", B + 32'hC, 16'h0);
        rd("async_ie", B, 16'h0);
        pin_in = 16'hFFFF;
        tick();
        tick();
        reset = 1'b0;
        wr(B, 16'hFFFF);
        wr(B + 32'h4, 16'hFFFF);
        wr(B + 32'h8, 16'hFFFF);
        tick();
        tick();
        rd("hi_pend", B + 32'hC, 16'h0);
        chk("hi_irq", {15'h0, irq}, 16'h0);

        // Edge coinciding with an enable write uses the old enables
        pin_in = 16'hFFFE;
        wr(B + 32'h8, 16'h0000);
        rd("old_en", B + 32'hC, 16'h0001);
        pin_in = 16'hFFFF;
        tick();
        pin_in = 16'h7FFF;
        tick();
        rd("new_en", B + 32'hC, 16'h0001);

        // Bus decoding
        wr(B, 16'h1234);
        rd("unmap_hi", B + 32'h14, 16'h0);
        rd("unmap_lo", B - 32'h4, 16'h0);
        wr(B + 32'h10, 16'h0000);
        rd("ro_active", B, 16'h1234);
        data_bus_select = 1'b0;
        data_bus_mode = 2'b10;
        data_bus_addr = B;
        data_bus_write = 16'h0000;
        tick();
        idle();
        rd("nosel_ie", B, 16'h1234);
        rd("nosel_rise", B + 32'h4, 16'hFFFF);

        // Randomized run
        for (int i = 0; i < 3000; i++) begin
            tick();
            if ($urandom_range(0, 2) == 0)
                pin_in = pin_in ^ (16'($urandom) & 16'($urandom));
            data_bus_select = 1'($urandom);
            data_bus_mode   = 2'($urandom);
            data_bus_addr   = addrs[$urandom_range(0, 7)];
            data_bus_write  = 16'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b1;
                #1;
                chk("rand_reset_irq", {15'h0, irq}, 16'h0);
                reset = 1'b0;
            end
        end
        idle();
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
